// File: rtl/xor128_stream_pkg.sv
// Shared constants for the xorshift128 generator bank: fallback seed words,
// step shift amounts and the controller state encoding.
package xor128_stream_pkg;

    localparam logic [31:0] DEF_SEED0 = 32'd123456789;
    localparam logic [31:0] DEF_SEED1 = 32'd362436069;
    localparam logic [31:0] DEF_SEED2 = 32'd521288629;
    localparam logic [31:0] DEF_SEED3 = 32'd88675123;

    localparam int unsigned SHIFT_X = 11;
    localparam int unsigned SHIFT_W = 19;
    localparam int unsigned SHIFT_T = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/xor128_step.sv
// One combinational xorshift128 step for a single lane.
// The new w word is also the lane's output word.
module xor128_step
    import xor128_stream_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    input  logic [31:0] w,
    output logic [31:0] x_next,
    output logic [31:0] y_next,
    output logic [31:0] z_next,
    output logic [31:0] w_next
);

    logic [31:0] t;

    always_comb begin
        t      = x ^ (x << SHIFT_X);
        x_next = y;
        y_next = z;
        z_next = w;
        w_next = (w ^ (w >> SHIFT_W)) ^ (t ^ (t >> SHIFT_T));
    end

endmodule

// File: rtl/xor128_stream.sv
// Bank of LANES xorshift128 generators behind a valid/ready stream.
// A load re-seeds every lane, primes one step, then each handshake advances all lanes.
module xor128_stream
    import xor128_stream_pkg::*;
#(
    parameter int          LANES = 8,
    parameter logic [31:0] SEED0 = DEF_SEED0,
    parameter logic [31:0] SEED1 = DEF_SEED1,
    parameter logic [31:0] SEED2 = DEF_SEED2,
    parameter logic [31:0] SEED3 = DEF_SEED3
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic [LANES*128-1:0]  iSeed,
    input  logic                  iLoad,
    output logic [LANES*32-1:0]   oData,
    output logic                  oValid,
    input  logic                  iReady,
    output logic                  oSeedErr,
    output logic [31:0]           oCount
);

    localparam logic [127:0] FALLBACK = {SEED3, SEED2, SEED1, SEED0};

    state_t              state;
    logic [127:0]        lane_q    [LANES];
    logic [127:0]        lane_nxt  [LANES];
    logic [127:0]        seed_fix  [LANES];
    logic [LANES-1:0]    seed_zero;
    logic [LANES*32-1:0] data_nxt;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [31:0] xn, yn, zn, wn;

        xor128_step u_step (
            .x      (lane_q[g][31:0]),
            .y      (lane_q[g][63:32]),
            .z      (lane_q[g][95:64]),
            .w      (lane_q[g][127:96]),
            .x_next (xn),
            .y_next (yn),
            .z_next (zn),
            .w_next (wn)
        );

        assign lane_nxt[g]          = {wn, zn, yn, xn};
        assign data_nxt[g*32 +: 32] = wn;
        // An all-zero state would lock the generator at zero forever.
        assign seed_zero[g] = (iSeed[g*128 +: 128] == 128'd0);
        assign seed_fix[g]  = seed_zero[g] ? FALLBACK : iSeed[g*128 +: 128];
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= ST_IDLE;
            oValid   <= 1'b0;
            oData    <= '0;
            oCount   <= '0;
            oSeedErr <= 1'b0;
            for (int l = 0; l < LANES; l++) lane_q[l] <= '0;
        end else if (iLoad) begin
            // Load outranks any handshake in the same cycle.
            for (int l = 0; l < LANES; l++) lane_q[l] <= seed_fix[l];
            oSeedErr <= oSeedErr | (|seed_zero);
            oCount   <= '0;
            oValid   <= 1'b0;
            state    <= ST_PRIME;
        end else begin
            case (state)
                ST_PRIME: begin
                    for (int l = 0; l < LANES; l++) lane_q[l] <= lane_nxt[l];
                    oData  <= data_nxt;
                    oValid <= 1'b1;
                    state  <= ST_RUN;
                end
                ST_RUN: begin
                    if (iReady) begin
                        for (int l = 0; l < LANES; l++) lane_q[l] <= lane_nxt[l];
                        oData  <= data_nxt;
                        oCount <= oCount + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor128_stream.sv
// Directed bench for xor128_stream: a sequence-level reference model checked every cycle,
// plus literal expectations from the reference xor128 sequence.
module tb_xor128_stream;

    localparam int LANES = 8;
    localparam int DW    = LANES * 32;
    localparam logic [31:0] S0 = 32'd123456789;
    localparam logic [31:0] S1 = 32'd362436069;
    localparam logic [31:0] S2 = 32'd521288629;
    localparam logic [31:0] S3 = 32'd88675123;

    logic                 iClk = 1'b0;
    logic                 iRst;
    logic [LANES*128-1:0] iSeed;
    logic                 iLoad;
    logic [DW-1:0]        oData;
    logic                 oValid;
    logic                 iReady;
    logic                 oSeedErr;
    logic [31:0]          oCount;

    xor128_stream #(.LANES(LANES)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iSeed    (iSeed),
        .iLoad    (iLoad),
        .oData    (oData),
        .oValid   (oValid),
        .iReady   (iReady),
        .oSeedErr (oSeedErr),
        .oCount   (oCount)
    );

    always #5 iClk = ~iClk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference generator: the classic C xor128 recurrence on a {w,z,y,x} state.
    function automatic logic [127:0] xs_next(input logic [127:0] s);
        logic [31:0] x, y, z, w, t;
        {w, z, y, x} = s;
        t = x ^ (x << 11);
        return {(w ^ (w >> 19)) ^ (t ^ (t >> 8)), w, z, y};
    endfunction

    function automatic logic [LANES*128-1:0] seed_set(input int k, input int zero_lane);
        logic [LANES*128-1:0] v;
        for (int l = 0; l < LANES; l++) begin
            v[l*128 +: 128] = {S3 ^ (32'(k) << 12) ^ 32'(l), S2 + 32'(l) * 32'd7,
                               S1 ^ (32'(l) << 4), S0 + 32'(k) * 32'd13 + 32'(l) * 32'd101};
            if (l == zero_lane) v[l*128 +: 128] = '0;
        end
        return v;
    endfunction

    // Model: after a load the next edge yields word 1; every accepted transfer yields the next word.
    logic [127:0]  m_state [LANES];
    logic [DW-1:0] m_data;
    logic          m_valid, m_err, m_pending;
    logic [31:0]   m_count;
    logic          chk_en = 1'b0;

    always @(posedge iClk) begin
        if (iRst) begin
            m_valid = 1'b0; m_pending = 1'b0; m_err = 1'b0;
            m_count = '0;   m_data = '0;
            for (int l = 0; l < LANES; l++) m_state[l] = '0;
            chk_en = 1'b1;
        end else if (iLoad) begin
            for (int l = 0; l < LANES; l++) begin
                logic [127:0] s;
                s = iSeed[l*128 +: 128];
                if (s == '0) begin
                    s = {S3, S2, S1, S0};
                    m_err = 1'b1;
                end
                m_state[l] = s;
            end
            m_count = '0; m_valid = 1'b0; m_pending = 1'b1;
        end else if (m_pending || (m_valid && iReady)) begin
            if (m_valid) m_count = m_count + 32'd1;
            for (int l = 0; l < LANES; l++) begin
                m_state[l] = xs_next(m_state[l]);
                m_data[l*32 +: 32] = m_state[l][127:96];
            end
            m_valid = 1'b1; m_pending = 1'b0;
        end
    end

    always @(negedge iClk) begin
        if (chk_en) begin
            chk("model_valid", DW'(oValid), DW'(m_valid));
            chk("model_data", oData, m_data);
            chk("model_count", DW'(oCount), DW'(m_count));
            chk("model_seederr", DW'(oSeedErr), DW'(m_err));
        end
    end

    initial begin
        iRst = 1'b1; iLoad = 1'b0; iReady = 1'b0; iSeed = '0;
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        chk("reset_valid", DW'(oValid), '0);
        chk("reset_count", DW'(oCount), '0);
        chk("reset_data", oData, '0);
        chk("reset_seederr", DW'(oSeedErr), '0);

        // Default seed in lane 0, first two words of the reference sequence
        iSeed = seed_set(0, -1);
        iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        chk("load_valid_low", DW'(oValid), '0);
        @(negedge iClk);
        chk("prime_valid", DW'(oValid), DW'(1'b1));
        chk("first_word", DW'(oData[31:0]), DW'(32'd3701687786));
        iReady = 1'b1;
        @(negedge iClk);
        chk("second_word", DW'(oData[31:0]), DW'(32'd458299110));
        chk("count_one", DW'(oCount), DW'(32'd1));
        repeat (999) @(negedge iClk);
        chk("count_1000", DW'(oCount), DW'(32'd1000));
        iReady = 1'b0;

        // Random backpressure
        for (int i = 0; i < 300; i++) begin
            @(negedge iClk);
            iReady = 1'($urandom_range(0, 1));
        end
        iReady = 1'b0;

        // Lane 3 all-zero seed falls back to the default sequence
        iSeed = seed_set(1, 3);
        iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        chk("zero_seed_err", DW'(oSeedErr), DW'(1'b1));
        @(negedge iClk);
        chk("lane3_fallback", DW'(oData[3*32 +: 32]), DW'(32'd3701687786));
        iReady = 1'b1;
        @(negedge iClk);
        chk("lane3_second", DW'(oData[3*32 +: 32]), DW'(32'd458299110));
        repeat (20) @(negedge iClk);

        // Reload during RUN with iReady high: no count, one invalid cycle, new sequence
        iSeed = seed_set(2, -1);
        iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        chk("reload_valid_low", DW'(oValid), '0);
        chk("reload_count", DW'(oCount), '0);
        chk("reload_err_sticky", DW'(oSeedErr), DW'(1'b1));
        @(negedge iClk);
        chk("reload_valid_high", DW'(oValid), DW'(1'b1));
        repeat (10) @(negedge iClk);
        iReady = 1'b0;

        // Counter wrap
        @(posedge iClk);
        #1;
        force dut.oCount = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        @(posedge iClk);
        #1;
        release dut.oCount;
        @(negedge iClk);
        chk("count_preset", DW'(oCount), DW'(32'hFFFF_FFFF));
        iReady = 1'b1;
        @(negedge iClk);
        chk("count_wrap", DW'(oCount), '0);
        repeat (3) @(negedge iClk);

        // Reset mid-RUN
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        chk("midrun_rst_valid", DW'(oValid), '0);
        chk("midrun_rst_count", DW'(oCount), '0);
        chk("midrun_rst_err", DW'(oSeedErr), '0);
        iSeed = seed_set(3, -1);
        iLoad = 1'b1;
        @(negedge iClk);
        iLoad = 1'b0;
        repeat (15) @(negedge iClk);
        iReady = 1'b0;
        repeat (2) @(negedge iClk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
